// File: rtl/pool_pkg.sv
// Shared types and default geometry for the 2x2/stride-2 max-pool sequencer.
// Contents: seq_state_t (sequencer FSM states), default pixel width and frame
// size, and the number of pooled outputs produced per frame.
package pool_pkg;

  localparam int unsigned POOL_DATA_W  = 8;
  localparam int unsigned POOL_IMG_W   = 32;
  localparam int unsigned POOL_IMG_H   = 32;
  localparam int unsigned POOL_OUT_CNT = (POOL_IMG_W / 2) * (POOL_IMG_H / 2);

  typedef enum logic [2:0] {
    IDLE,
    STREAM,
    FLUSH,
    DRAIN,
    DONE
  } seq_state_t;

endpackage

// File: rtl/pool_pos_counter.sv
// Raster position tracker for the incoming feature map.
// Ports:
//   clk, rst      clock / asynchronous active-high reset
//   clr_i         return to (row 0, col 0)
//   adv_i         one pixel accepted at the current position
//   last_pix_c_o  current position is the final pixel of the frame
//   win_done_c_o  current position (odd row, odd col) closes a 2x2 window
module pool_pos_counter
  import pool_pkg::*;
#(
  parameter int unsigned IMG_W = POOL_IMG_W,
  parameter int unsigned IMG_H = POOL_IMG_H
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic adv_i,
  output logic last_pix_c_o,
  output logic win_done_c_o
);

  localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             col_wrap_c;
  logic             row_wrap_c;

  assign col_wrap_c = (col_q == COL_W'(IMG_W - 1));
  assign row_wrap_c = (row_q == ROW_W'(IMG_H - 1));

  // Next position: col wraps into row, row wraps at frame end.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr_i) begin
      col_d = '0;
      row_d = '0;
    end else if (adv_i) begin
      if (col_wrap_c) begin
        col_d = '0;
        row_d = row_wrap_c ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign last_pix_c_o = col_wrap_c && row_wrap_c;
  // IMG_W and IMG_H are even, so odd row/col is the bottom-right of a window.
  assign win_done_c_o = col_q[0] && row_q[0];

endmodule

// File: rtl/pool_sequencer.sv
// Sequencer for one 2x2/stride-2 max-pool core: accepts a raster frame on a
// valid/ready stream, pushes pixels (then zero flush pushes) into the core,
// fires the core's output enable CAL_DLY cycles after the window-loading
// push, and holds each pooled result in a 1-entry output register.
// Ports:
//   clk, rst                         clock / asynchronous active-high reset
//   start                            begin a frame (only honoured in IDLE)
//   s_valid, s_ready, s_data         input pixel stream
//   pool_din_valid, pool_din         push strobe / pixel to the core
//   pool_cal_valid                   core output enable
//   pool_dout                        core pooled result (registered in core)
//   m_valid, m_ready, m_data         pooled pixel stream
//   busy                             any state except IDLE
//   frame_done                       one-cycle end-of-frame pulse
//   stall_cnt                        (POOL_SEQ_PERF_EN only) STREAM cycles
//                                    with s_valid high and s_ready low
// Build option: define POOL_SEQ_PERF_EN to add the stall_cnt port/counter.
// WIN_SKEW and CAL_DLY must both be >= 1.
module pool_sequencer
  import pool_pkg::*;
#(
  parameter int unsigned IMG_W    = POOL_IMG_W,
  parameter int unsigned IMG_H    = POOL_IMG_H,
  parameter int unsigned DATA_W   = POOL_DATA_W,
  parameter int unsigned WIN_SKEW = 1,
  parameter int unsigned CAL_DLY  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              pool_din_valid,
  output logic [DATA_W-1:0] pool_din,
  output logic              pool_cal_valid,
  input  logic [DATA_W-1:0] pool_dout,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              busy,
  output logic              frame_done
`ifdef POOL_SEQ_PERF_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int unsigned SKW_W = (WIN_SKEW > 1) ? $clog2(WIN_SKEW) : 1;
  localparam int unsigned DLY_W = $clog2(CAL_DLY + 2);

  seq_state_t        state_q, state_d;
  logic              pending_q, pending_d;
  logic [DLY_W-1:0]  dly_q, dly_d;
  logic              armed_q, armed_d;
  logic [SKW_W-1:0]  skew_q, skew_d;
  logic              cal_q, cal_d;
  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic s_ready_c;
  logic accept_c;
  logic flush_push_c;
  logic push_c;
  logic load_c;
  logic capture_c;
  logic start_c;
  logic last_pix_c;
  logic win_done_c;

  assign start_c      = start && (state_q == IDLE);
  assign s_ready_c    = (state_q == STREAM) && !pending_q && !m_valid_q;
  assign accept_c     = s_valid && s_ready_c;
  // Flush pushes obey the same one-window-in-flight rule as stream pushes.
  assign flush_push_c = (state_q == FLUSH) && !pending_q && !m_valid_q;
  assign push_c       = accept_c || flush_push_c;
  // The WIN_SKEW-th push after a window-completing pixel loads that window.
  assign load_c       = push_c && armed_q && (skew_q == SKW_W'(WIN_SKEW - 1));
  // pool_dout is valid the cycle after the enable; latch it then.
  assign capture_c    = pending_q && (dly_q == DLY_W'(CAL_DLY + 1));

  pool_pos_counter #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H)
  ) u_pos (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (start_c),
    .adv_i       (accept_c),
    .last_pix_c_o(last_pix_c),
    .win_done_c_o(win_done_c)
  );

  // Next-state: FSM, skew/delay tracking, output register.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    dly_d     = dly_q;
    armed_d   = armed_q;
    skew_d    = skew_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;

    unique case (state_q)
      IDLE:    if (start) state_d = STREAM;
      STREAM:  if (accept_c && last_pix_c) state_d = FLUSH;
      FLUSH:   if (load_c) state_d = DRAIN;
      DRAIN:   if (!pending_q && !m_valid_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (start_c) begin
      armed_d = 1'b0;
      skew_d  = '0;
    end else if (push_c) begin
      if (load_c) begin
        armed_d = 1'b0;
        skew_d  = '0;
      end else if (armed_q) begin
        skew_d = skew_q + SKW_W'(1);
      end
      if (accept_c && win_done_c) begin
        armed_d = 1'b1;
        skew_d  = '0;
      end
    end

    if (load_c) begin
      pending_d = 1'b1;
      dly_d     = DLY_W'(1);
    end else if (capture_c) begin
      pending_d = 1'b0;
      dly_d     = '0;
    end else if (pending_q) begin
      dly_d = dly_q + DLY_W'(1);
    end

    // Capture wins over drain so a same-cycle drain+capture reloads.
    if (capture_c) begin
      m_valid_d = 1'b1;
      m_data_d  = pool_dout;
    end else if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end

    cal_d  = pending_d && (dly_d == DLY_W'(CAL_DLY));
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      dly_q     <= '0;
      armed_q   <= 1'b0;
      skew_q    <= '0;
      cal_q     <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      dly_q     <= dly_d;
      armed_q   <= armed_d;
      skew_q    <= skew_d;
      cal_q     <= cal_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign s_ready        = s_ready_c;
  assign pool_din_valid = push_c;
  assign pool_din       = accept_c ? s_data : '0;
  assign pool_cal_valid = cal_q;
  assign m_valid        = m_valid_q;
  assign m_data         = m_data_q;
  assign busy           = busy_q;
  assign frame_done     = done_q;

`ifdef POOL_SEQ_PERF_EN
  logic [15:0] stall_q, stall_d;

  // Saturating count of offered-but-refused input cycles.
  always_comb begin
    stall_d = stall_q;
    if (start_c) begin
      stall_d = '0;
    end else if ((state_q == STREAM) && s_valid && !s_ready_c && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_pool_sequencer.sv
module tb_pool_sequencer;
  import pool_pkg::*;

  localparam int W    = int'(POOL_IMG_W);
  localparam int H    = int'(POOL_IMG_H);
  localparam int N    = W * H;
  localparam int OUTS = int'(POOL_OUT_CNT);
  localparam int SK   = 1;
  localparam int CD   = 2;

  logic       clk;
  logic       rst;
  logic       start;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       pool_din_valid;
  logic [7:0] pool_din;
  logic       pool_cal_valid;
  logic [7:0] pool_dout;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       busy;
  logic       frame_done;
`ifdef POOL_SEQ_PERF_EN
  logic [15:0] stall_cnt;
`endif

  pool_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .pool_din_valid(pool_din_valid),
    .pool_din      (pool_din),
    .pool_cal_valid(pool_cal_valid),
    .pool_dout     (pool_dout),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .busy          (busy),
    .frame_done    (frame_done)
`ifdef POOL_SEQ_PERF_EN
    ,
    .stall_cnt     (stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] max4(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c, input logic [7:0] d);
    logic [7:0] m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Push index k loads the window closed by push k-SK (odd row, odd col).
  function automatic bit is_load(input int k);
    int w;
    w = k - SK;
    if (w < 0 || w >= N) return 1'b0;
    return (((w / W) % 2) == 1) && (((w % W) % 2) == 1);
  endfunction

  function automatic logic [31:0] outs_vec();
    return 32'({m_valid, m_data, s_ready, pool_din_valid, pool_din, pool_cal_valid, busy, frame_done});
  endfunction

  // Behavioural pooling core: stores pushed pixels, loads a window on the
  // loading push, and registers its max on the output enable.
  logic [7:0] pix [0:N-1];
  int         core_idx;
  logic [7:0] core_win;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      core_idx  <= 0;
      core_win  <= 8'h00;
      pool_dout <= 8'h00;
    end else begin
      if (start && !busy) begin
        core_idx <= 0;
      end else if (pool_din_valid) begin
        if (core_idx < N) pix[core_idx] <= pool_din;
        if (is_load(core_idx))
          core_win <= max4(pix[core_idx - SK - W - 1], pix[core_idx - SK - W],
                           pix[core_idx - SK - 1], pix[core_idx - SK]);
        core_idx <= core_idx + 1;
      end
      if (pool_cal_valid) pool_dout <= core_win;
    end
  end

  // Scoreboard / monitor
  logic [7:0] img [0:N-1];
  logic [7:0] exp_q[$];
  logic [7:0] out_log [0:OUTS-1];
  int         cal_exp_q[$];
  int         cyc      = 0;
  int         mon_push = 0;
  int         out_cnt  = 0;
  int         done_cnt = 0;
  bit         prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;
  bit         exp_cal;
  logic [7:0] e;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        mon_push  = 0;
        out_cnt   = 0;
        prev_hold = 1'b0;
        cal_exp_q.delete();
      end else begin
        if (start && !busy) begin
          mon_push = 0;
          out_cnt  = 0;
        end
        exp_cal = (cal_exp_q.size() > 0) && (cal_exp_q[0] == cyc);
        if (exp_cal) void'(cal_exp_q.pop_front());
        if (exp_cal || pool_cal_valid) chk("cal_timing", 32'(pool_cal_valid), 32'(exp_cal));
        if (pool_din_valid) begin
          if (is_load(mon_push)) cal_exp_q.push_back(cyc + CD);
          if (mon_push >= N) chk("flush_din_zero", 32'(pool_din), 32'h0);
          mon_push++;
        end
        if (prev_hold) begin
          chk("hold_valid", 32'(m_valid), 32'h1);
          chk("hold_data", 32'(m_data), 32'(prev_data));
        end
        if (m_valid) chk("s_ready_while_full", 32'(s_ready), 32'h0);
        if (m_valid && m_ready) begin
          chk("out_expected", 32'(exp_q.size() > 0), 32'h1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pool_out", 32'(m_data), 32'(e));
          end
          if (out_cnt < OUTS) out_log[out_cnt] = m_data;
          out_cnt++;
        end
        if (frame_done) begin
          done_cnt++;
          chk("outs_at_done", 32'(out_cnt), 32'(OUTS));
        end
        prev_hold = m_valid && !m_ready;
        prev_data = m_data;
      end
    end
  end

  // Downstream ready driver
  int m_hold     = 0;
  bit rand_ready = 1'b0;

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (m_hold > 0) begin
        m_ready = 1'b0;
        m_hold--;
      end else begin
        m_ready = rand_ready ? 1'($urandom_range(1)) : 1'b1;
      end
    end
  end

  int stalls = 0;

  task automatic load_expected();
    for (int wr = 0; wr < H / 2; wr++)
      for (int wc = 0; wc < W / 2; wc++)
        exp_q.push_back(max4(img[(2*wr)*W + 2*wc], img[(2*wr)*W + 2*wc + 1],
                             img[(2*wr+1)*W + 2*wc], img[(2*wr+1)*W + 2*wc + 1]));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_pixels(input int n, input int gap, input int hold_at,
                             input int hold_len, input int bstart_at);
    int idx;
    int guard;
    bit acc;
    idx   = 0;
    guard = 0;
    s_valid = 1'b0;
    while (idx < n && guard < 20000) begin
      if (!s_valid) s_valid = (int'($urandom_range(99)) >= gap);
      s_data = s_valid ? img[idx] : 8'($urandom);
      start  = (idx == bstart_at);
      if (idx == hold_at) begin
        m_hold  = hold_len;
        hold_at = -1;
      end
      @(negedge clk);
      acc = s_valid && s_ready;
      if (s_valid && !s_ready) stalls++;
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        s_valid = 1'b0;
      end
      guard++;
    end
    s_valid = 1'b0;
    start   = 1'b0;
    if (guard >= 20000) chk("send_budget", 32'(idx), 32'(n));
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge clk);
      if (frame_done) seen = 1'b1;
    end
    chk("frame_done_seen", 32'(seen), 32'h1);
    @(negedge clk);
    chk("done_one_cycle", 32'(frame_done), 32'h0);
    chk("idle_after_done", 32'(busy), 32'h0);
    chk("sb_empty", 32'(exp_q.size()), 32'h0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int gap, input int hold_at, input int hold_len, input int bstart_at);
    load_expected();
    stalls = 0;
    pulse_start();
    chk("busy_after_start", 32'(busy), 32'h1);
`ifdef POOL_SEQ_PERF_EN
    chk("stall_clear", 32'(stall_cnt), 32'h0);
`endif
    send_pixels(N, gap, hold_at, hold_len, bstart_at);
    wait_done();
`ifdef POOL_SEQ_PERF_EN
    chk("stall_cnt", 32'(stall_cnt), 32'(stalls));
`endif
  endtask

  task automatic rand_img();
    for (int i = 0; i < N; i++) img[i] = 8'($urandom);
  endtask

  int done_before;

  initial begin
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    rst     = 1'b0;
    #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", outs_vec(), 32'h0);
`ifdef POOL_SEQ_PERF_EN
    chk("reset_stall_cnt", 32'(stall_cnt), 32'h0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Ramp frame, free-flowing output
    for (int i = 0; i < N; i++) img[i] = 8'(((i / W) * W + (i % W)) & 255);
    run_frame(0, -1, 0, -1);
    chk("ramp_first_out", 32'(out_log[0]), 32'd33);
    chk("ramp_done_pulses", 32'(done_cnt), 32'd1);

    // Constant frame with one peak at row 5, col 9
    for (int i = 0; i < N; i++) img[i] = 8'h7F;
    img[5*W + 9] = 8'hFF;
    run_frame(0, -1, 0, -1);
    chk("peak_out", 32'(out_log[2*(W/2) + 4]), 32'hFF);
    chk("peak_neighbour", 32'(out_log[2*(W/2) + 5]), 32'h7F);
    chk("peak_done_pulses", 32'(done_cnt), 32'd2);

    // Downstream stalled 20 cycles mid-frame
    rand_img();
    run_frame(0, 400, 20, -1);

    // Random input gaps, random m_ready, start pulse while busy
    rand_img();
    rand_ready = 1'b1;
    run_frame(50, -1, 0, 500);
    rand_ready = 1'b0;
    chk("busy_start_ignored", 32'(done_cnt), 32'd4);

    // Reset mid-row, then a full frame
    rand_img();
    load_expected();
    pulse_start();
    send_pixels(100, 0, -1, 0, -1);
    done_before = done_cnt;
    s_valid = 1'b1;
    s_data  = 8'hAA;
    rst     = 1'b1;
    @(negedge clk);
    chk("midframe_rst_outputs", outs_vec(), 32'h0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("midframe_rst_hold", outs_vec(), 32'h0);
    @(posedge clk);
    #1;
    rst     = 1'b0;
    s_valid = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    chk("no_done_partial", 32'(done_cnt), 32'(done_before));
    rand_img();
    run_frame(50, -1, 0, -1);

`ifdef POOL_SEQ_PERF_EN
    // Downstream held off 10 cycles with input always offered
    rand_img();
    run_frame(0, 300, 10, -1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
